reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Shares the single register-file write port (REG_address_wr / REG_write_enable / REG_write_data) among several write-back requesters: pipeline WB, load unit, mult/div unit.
- Arbitration is round-robin.
- Holds a 32-entry pending-write scoreboard so the issue stage can stall on RAW/WAW hazards against long-latency results.
- Sits between the execution units and the register file; the register file commits on negedge of the same clk.

Parameters:
NUM_REQ, 3, number of write-back requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register address width (32 GPRs)

Ports:
clk  in  1  system clock, all state on posedge
SYS_reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester write request
req_addr  in  NUM_REQ*ADDR_W  destination register, requester i in slice i
req_data  in  NUM_REQ*DATA_W  write data, requester i in slice i
req_ready  out  NUM_REQ  grant/accept, combinational, one-hot or zero
rsv_valid  in  1  issue stage reserves a destination for a multi-cycle op
rsv_addr  in  ADDR_W  register being reserved
rsv_ready  out  1  reservation accepted this cycle
busy_vec  out  32  scoreboard, bit r = write to r pending
REG_address_wr  out  ADDR_W  to register file
REG_write_enable  out  1  to register file
REG_write_data  out  DATA_W  to register file
err_unreserved  out  1  sticky: completion to a non-busy nonzero register from a requester >0

Behaviour:
- Reset (async assert, sync release):
  - REG_write_enable=0, REG_address_wr=0, REG_write_data=0.
  - busy_vec=0, rr pointer=0, err_unreserved=0.
- Handshake:
  - Transfer on req_valid[i] & req_ready[i].
  - Requester holds valid/addr/data stable until accepted; no retraction.
- Arbitration:
  - Among asserted req_valid, grant the first index at or after the rr pointer, wrapping modulo NUM_REQ.
  - At most one grant per cycle.
  - After a grant to i, pointer <= (i+1) mod NUM_REQ. Pointer is unchanged when there is no grant.
- Write issue:
  - Registered, 1-cycle latency.
  - Grant in cycle N gives REG_write_enable=1 with addr/data in cycle N+1. The register file commits at the negedge of N+1.
  - REG_write_enable=0 in any cycle following a no-grant cycle.
- Register $0:
  - A request to addr 0 is granted and consumes the slot.
  - The pointer advances, but REG_write_enable stays 0 and busy is untouched.
- Scoreboard:
  - rsv_ready = (rsv_addr==0) | ~busy_vec[rsv_addr], evaluated on registered busy_vec.
  - On rsv_valid & rsv_ready with addr≠0: busy[addr] <= 1.
  - On a granted request to addr≠0: busy[addr] <= 0.
  - A grant and an accepted reservation to the same register in one cycle cannot occur (rsv_ready is low when busy). For different registers, both updates apply.
- err_unreserved:
  - Set when requester i>0 is granted to nonzero addr with busy[addr]=0.
  - Requester 0 (pipeline WB) never needs a reservation.
  - Cleared only by reset.
- Reset mid-operation:
  - Pending reservations are dropped.
  - An in-flight write in its N+1 cycle is forced to REG_write_enable=0 immediately.
- Width: NUM_REQ not a power of two; pointer wrap uses an explicit compare, not a bit truncation.

Decomposition:
- Package reg_arb_pkg:
  - NUM_GPR=32, ADDR_W=5, DATA_W=32, ZERO_REG=5'd0.
  - wb_req_t struct (valid, addr, data).
- Sub-module rr_arbiter:
  - Parameter N; inputs req[N], ptr; outputs grant one-hot, grant_idx, any.
  - Purely combinational.
  - Pointer register lives in the parent.

Test Plan:
1. Reset, then req_valid=3'b111, addrs 5/6/7, data A/B/C held:
   - Grants 0,1,2 in consecutive cycles.
   - REG_write_enable high for 3 cycles with (5,A),(6,B),(7,C), each 1 cycle after its grant.
2. rsv_valid addr=9:
   - busy_vec[9]=1 next cycle.
   - Second rsv addr=9 gives rsv_ready=0.
   - Requester 2 writes 9 → busy_vec[9]=0 next cycle; rsv addr=9 then accepted.
3. Request addr=0 from requester 1 with data 32'hDEADBEEF:
   - req_ready[1]=1, REG_write_enable stays 0, pointer moves to 2, busy_vec unchanged.
4. Requester 1 writes addr 12 with no prior reservation:
   - err_unreserved=1 next cycle and stays set.
   - Same case from requester 0 leaves it 0.
5. Starvation check, NUM_REQ=3:
   - Requester 0 asserts valid continuously while requester 2 asserts once.
   - Requester 2 is granted within 3 cycles.
6. Assert SYS_reset_n=0 asynchronously in the cycle REG_write_enable=1 with busy_vec=32'h0000_0200:
   - REG_write_enable, busy_vec and the pointer go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and constants for the register write-back arbiter.
// Register file geometry and the write-back request bundle.
package reg_arb_pkg;

   localparam int NUM_GPR = 32;
   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 32;

   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Write-back bus between execution units, issue stage and register file.
// The slave side is the arbiter, the master side drives requests.
interface reg_wb_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      rsv_valid;
   logic [ADDR_W-1:0]         rsv_addr;
   logic                      rsv_ready;
   logic [31:0]               busy_vec;
   logic [ADDR_W-1:0]         REG_address_wr;
   logic                      REG_write_enable;
   logic [DATA_W-1:0]         REG_write_data;
   logic                      err_unreserved;

   modport slave (
      input  req_valid, req_addr, req_data,
      input  rsv_valid, rsv_addr,
      output req_ready, rsv_ready, busy_vec,
      output REG_address_wr, REG_write_enable,
      output REG_write_data, err_unreserved
   );

   modport master (
      output req_valid, req_addr, req_data,
      output rsv_valid, rsv_addr,
      input  req_ready, rsv_ready, busy_vec,
      input  REG_address_wr, REG_write_enable,
      input  REG_write_data, err_unreserved
   );

endinterface

// File: rtl/reg_wb_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr.
// The pointer register is owned by the caller.
module rr_arbiter #(
   parameter int N = 3,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx,
   output logic          any
);

   int idx;

   // scan N positions starting at ptr, wrapping by explicit compare
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter for the register-file write port with a
// pending-write scoreboard for long-latency results.
module reg_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5
) (
   input logic          clk,
   input logic          SYS_reset_n,
   reg_wb_arbiter_if.slave bus
);

   import reg_arb_pkg::*;

   localparam int PW = $clog2(NUM_REQ);

   logic [PW-1:0]      ptr_q, ptr_d, grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic               any;
   wb_req_t            win;
   logic               real_wr, rsv_ok, unrsv;
   logic [NUM_GPR-1:0] busy_q, busy_d;
   logic               err_q;
   logic               we_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  data_q;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req       (bus.req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any)
   );

   assign bus.req_ready = grant;

   // select the granted requester's address and data
   always_comb begin
      win       = '0;
      win.valid = any;
      win.addr  = bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
      win.data  = bus.req_data[int'(grant_idx)*DATA_W +: DATA_W];
   end

   assign real_wr = win.valid && (win.addr != ZERO_REG);
   assign bus.rsv_ready = (bus.rsv_addr == ZERO_REG) |
                          ~busy_q[bus.rsv_addr];
   assign rsv_ok  = bus.rsv_valid && bus.rsv_ready &&
                    (bus.rsv_addr != ZERO_REG);
   assign unrsv   = real_wr && (grant_idx != '0) &&
                    !busy_q[win.addr];

   // next pointer and scoreboard update
   always_comb begin
      ptr_d  = ptr_q;
      busy_d = busy_q;
      if (any) begin
         if (grant_idx == PW'(NUM_REQ-1)) ptr_d = '0;
         else                             ptr_d = grant_idx + 1'b1;
      end
      if (rsv_ok)  busy_d[bus.rsv_addr] = 1'b1;
      if (real_wr) busy_d[win.addr]     = 1'b0;
   end

   // arbitration state, scoreboard and registered write port
   always_ff @(posedge clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         ptr_q  <= '0;
         busy_q <= '0;
         err_q  <= 1'b0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         busy_q <= busy_d;
         err_q  <= err_q | unrsv;
         we_q   <= real_wr;
         if (real_wr) begin
            addr_q <= win.addr;
            data_q <= win.data;
         end
      end
   end

   assign bus.busy_vec         = busy_q;
   assign bus.err_unreserved   = err_q;
   assign bus.REG_write_enable = we_q;
   assign bus.REG_address_wr   = addr_q;
   assign bus.REG_write_data   = data_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with hand-computed expectations.
// Inputs change 1ns after posedge, outputs are checked before the next.
module tb_reg_wb_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   int   waited;
   bit   got;

   always #5 clk = ~clk;

   reg_wb_arbiter_if #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) bus ();

   reg_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
      .clk         (clk),
      .SYS_reset_n (rst_n),
      .bus         (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [4:0] a,
                          input logic [31:0] d);
      bus.req_addr[i*5 +: 5]   = a;
      bus.req_data[i*32 +: 32] = d;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      bus.rsv_valid = 1'b0;
      bus.rsv_addr  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we", 32'(bus.REG_write_enable), 0);
      chk("rst_addr", 32'(bus.REG_address_wr), 0);
      chk("rst_data", bus.REG_write_data, 0);
      chk("rst_busy", bus.busy_vec, 0);
      chk("rst_err", 32'(bus.err_unreserved), 0);
      #2 rst_n = 1'b1;

      // reserve 6 and 7 so requesters 1/2 write reserved registers
      tick;
      bus.rsv_valid = 1'b1;
      bus.rsv_addr  = 5'd6;
      #1 chk("rsv6_ready", 32'(bus.rsv_ready), 1);
      tick;
      chk("busy_6", bus.busy_vec, 32'h40);
      bus.rsv_addr = 5'd7;
      #1 chk("rsv7_ready", 32'(bus.rsv_ready), 1);
      tick;
      bus.rsv_valid = 1'b0;
      chk("busy_67", bus.busy_vec, 32'hC0);

      // test 1: three requesters, consecutive grants
      set_req(0, 5'd5, 32'hAAAA_0001);
      set_req(1, 5'd6, 32'hBBBB_0002);
      set_req(2, 5'd7, 32'hCCCC_0003);
      bus.req_valid = 3'b111;
      #1 chk("t1_gnt0", 32'(bus.req_ready), 32'b001);
      tick;
      chk("t1_we0", 32'(bus.REG_write_enable), 1);
      chk("t1_addr0", 32'(bus.REG_address_wr), 5);
      chk("t1_data0", bus.REG_write_data, 32'hAAAA_0001);
      bus.req_valid = 3'b110;
      #1 chk("t1_gnt1", 32'(bus.req_ready), 32'b010);
      tick;
      chk("t1_we1", 32'(bus.REG_write_enable), 1);
      chk("t1_addr1", 32'(bus.REG_address_wr), 6);
      chk("t1_data1", bus.REG_write_data, 32'hBBBB_0002);
      chk("t1_busy1", bus.busy_vec, 32'h80);
      bus.req_valid = 3'b100;
      #1 chk("t1_gnt2", 32'(bus.req_ready), 32'b100);
      tick;
      chk("t1_we2", 32'(bus.REG_write_enable), 1);
      chk("t1_addr2", 32'(bus.REG_address_wr), 7);
      chk("t1_data2", bus.REG_write_data, 32'hCCCC_0003);
      chk("t1_busy2", bus.busy_vec, 0);
      bus.req_valid = 3'b000;
      #1 chk("t1_nogrant", 32'(bus.req_ready), 0);
      tick;
      chk("t1_we_idle", 32'(bus.REG_write_enable), 0);
      chk("t1_err", 32'(bus.err_unreserved), 0);

      // test 2: reservation on 9, blocked, cleared by requester 2
      bus.rsv_valid = 1'b1;
      bus.rsv_addr  = 5'd9;
      #1 chk("t2_rsv_ok", 32'(bus.rsv_ready), 1);
      tick;
      chk("t2_busy9", bus.busy_vec, 32'h200);
      #1 chk("t2_rsv_blk", 32'(bus.rsv_ready), 0);
      bus.rsv_valid = 1'b0;
      set_req(2, 5'd9, 32'h9999_0009);
      bus.req_valid = 3'b100;
      #1 chk("t2_gnt2", 32'(bus.req_ready), 32'b100);
      tick;
      bus.req_valid = 3'b000;
      chk("t2_busy_clr", bus.busy_vec, 0);
      chk("t2_we", 32'(bus.REG_write_enable), 1);
      chk("t2_addr", 32'(bus.REG_address_wr), 9);
      chk("t2_err", 32'(bus.err_unreserved), 0);
      bus.rsv_valid = 1'b1;
      bus.rsv_addr  = 5'd9;
      #1 chk("t2_rsv_again", 32'(bus.rsv_ready), 1);
      tick;
      bus.rsv_valid = 1'b0;
      chk("t2_busy9b", bus.busy_vec, 32'h200);

      // test 3: write to $0 consumes the slot, pointer 0 -> 2
      set_req(1, 5'd0, 32'hDEAD_BEEF);
      bus.req_valid = 3'b010;
      #1 chk("t3_gnt1", 32'(bus.req_ready), 32'b010);
      tick;
      chk("t3_we0", 32'(bus.REG_write_enable), 0);
      chk("t3_busy", bus.busy_vec, 32'h200);
      set_req(0, 5'd3, 32'h3333_0003);
      bus.req_valid = 3'b011;
      #1 chk("t3_ptr2", 32'(bus.req_ready), 32'b001);
      tick;
      chk("t3_we", 32'(bus.REG_write_enable), 1);
      chk("t3_addr", 32'(bus.REG_address_wr), 3);
      chk("t3_data", bus.REG_write_data, 32'h3333_0003);
      bus.req_valid = 3'b010;
      #1 chk("t3_gnt1b", 32'(bus.req_ready), 32'b010);
      tick;
      bus.req_valid = 3'b000;
      chk("t3_we0b", 32'(bus.REG_write_enable), 0);
      chk("t3_err", 32'(bus.err_unreserved), 0);

      // test 4: unreserved completion from requester 1
      set_req(1, 5'd12, 32'h1212_000C);
      bus.req_valid = 3'b010;
      #1 chk("t4_gnt1", 32'(bus.req_ready), 32'b010);
      tick;
      bus.req_valid = 3'b000;
      chk("t4_err_set", 32'(bus.err_unreserved), 1);
      chk("t4_addr", 32'(bus.REG_address_wr), 12);
      tick;
      chk("t4_err_hold", 32'(bus.err_unreserved), 1);
      chk("t4_we_idle", 32'(bus.REG_write_enable), 0);

      // test 5: requester 0 continuous, requester 2 once
      set_req(0, 5'd1, 32'h1111_0001);
      bus.req_valid = 3'b001;
      #1 chk("t5_gnt0", 32'(bus.req_ready), 32'b001);
      tick;
      set_req(2, 5'd9, 32'h2929_0009);
      bus.req_valid = 3'b101;
      waited = 0;
      got    = 1'b0;
      for (int k = 0; k < 3 && !got; k++) begin
         #1;
         if (bus.req_ready[2]) got = 1'b1;
         else begin
            @(posedge clk);
            waited++;
         end
      end
      chk("t5_got2", 32'(got), 1);
      chk("t5_wait", waited, 0);
      tick;
      bus.req_valid = 3'b001;
      chk("t5_busy", bus.busy_vec, 0);
      #1 chk("t5_gnt0b", 32'(bus.req_ready), 32'b001);
      tick;
      bus.req_valid = 3'b000;
      chk("t5_addr1", 32'(bus.REG_address_wr), 1);
      bus.rsv_valid = 1'b1;
      bus.rsv_addr  = 5'd9;
      tick;
      bus.rsv_valid = 1'b0;
      chk("t5_busy9", bus.busy_vec, 32'h200);

      // test 6: async reset during an issued write
      set_req(0, 5'd3, 32'h3333_0033);
      bus.req_valid = 3'b001;
      #1 chk("t6_gnt0", 32'(bus.req_ready), 32'b001);
      tick;
      bus.req_valid = 3'b000;
      chk("t6_we_pre", 32'(bus.REG_write_enable), 1);
      chk("t6_busy_pre", bus.busy_vec, 32'h200);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_we_rst", 32'(bus.REG_write_enable), 0);
      chk("t6_busy_rst", bus.busy_vec, 0);
      chk("t6_err_rst", 32'(bus.err_unreserved), 0);
      chk("t6_addr_rst", 32'(bus.REG_address_wr), 0);
      #2 rst_n = 1'b1;
      tick;
      set_req(0, 5'd12, 32'h0C0C_000C);
      set_req(2, 5'd0, 32'h0);
      bus.req_valid = 3'b101;
      #1 chk("t6_ptr0", 32'(bus.req_ready), 32'b001);
      tick;
      bus.req_valid = 3'b100;
      chk("t6_we", 32'(bus.REG_write_enable), 1);
      chk("t6_addr", 32'(bus.REG_address_wr), 12);
      chk("t6_err_req0", 32'(bus.err_unreserved), 0);
      #1 chk("t6_gnt2", 32'(bus.req_ready), 32'b100);
      tick;
      bus.req_valid = 3'b000;
      chk("t6_we_zero", 32'(bus.REG_write_enable), 0);
      chk("t6_err_end", 32'(bus.err_unreserved), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
